// File: rtl/cache_ctrl_if.sv
// Bundle of CPU, cache-array and main-memory signals around cache_ctrl.
// master is the controller's view; slave is the surrounding system.
interface cache_ctrl_if #(
    parameter int ADDR_BITS = 32,
    parameter int TAG_BITS  = 23,
    parameter int CNT_BITS  = 32
);
    logic                 cpu_req_i;
    logic                 cpu_we_i;
    logic [ADDR_BITS-1:0] cpu_addr_i;
    logic [2:0]           cpu_ubhw_i;
    logic [31:0]          cpu_data_i;
    logic [31:0]          cpu_data_o;
    logic                 cpu_ready_o;

    logic [ADDR_BITS-1:0] cache_addr_o;
    logic                 cache_load_o;
    logic                 cache_edit_o;
    logic                 cache_store_o;
    logic                 cache_inv_o;
    logic [2:0]           cache_ubhw_o;
    logic [31:0]          cache_din_o;
    logic                 cache_hit_i;
    logic [31:0]          cache_dout_i;
    logic                 cache_valid_i;
    logic                 cache_dirty_i;
    logic [TAG_BITS-1:0]  cache_tag_i;

    logic                 mem_cs_o;
    logic                 mem_we_o;
    logic [ADDR_BITS-1:0] mem_addr_o;
    logic [31:0]          mem_data_o;
    logic [31:0]          mem_data_i;
    logic                 mem_ack_i;

    logic [CNT_BITS-1:0]  hit_cnt_o;
    logic [CNT_BITS-1:0]  miss_cnt_o;

    modport master (
        input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_ubhw_i, cpu_data_i,
        output cpu_data_o, cpu_ready_o,
        output cache_addr_o, cache_load_o, cache_edit_o, cache_store_o,
        output cache_inv_o, cache_ubhw_o, cache_din_o,
        input  cache_hit_i, cache_dout_i, cache_valid_i, cache_dirty_i,
        input  cache_tag_i,
        output mem_cs_o, mem_we_o, mem_addr_o, mem_data_o,
        input  mem_data_i, mem_ack_i,
        output hit_cnt_o, miss_cnt_o
    );

    modport slave (
        output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_ubhw_i, cpu_data_i,
        input  cpu_data_o, cpu_ready_o,
        input  cache_addr_o, cache_load_o, cache_edit_o, cache_store_o,
        input  cache_inv_o, cache_ubhw_o, cache_din_o,
        output cache_hit_i, cache_dout_i, cache_valid_i, cache_dirty_i,
        output cache_tag_i,
        input  mem_cs_o, mem_we_o, mem_addr_o, mem_data_o,
        output mem_data_i, mem_ack_i,
        input  hit_cnt_o, miss_cnt_o
    );
endinterface

// File: rtl/cache_ctrl.sv
// Write-back controller for a 2-way set-associative cache: lookup,
// dirty victim write-back, word-by-word refill and request replay.
module cache_ctrl #(
    parameter int ADDR_BITS  = 32,
    parameter int TAG_BITS   = 23,
    parameter int INDEX_BITS = 5,
    parameter int WORD_BITS  = 2,
    parameter int CNT_BITS   = 32
) (
    input logic          clk,
    input logic          rst,
    cache_ctrl_if.master bus
);
    localparam int OFF_BITS = ADDR_BITS - TAG_BITS - INDEX_BITS - WORD_BITS;
    localparam int IDX_LO   = OFF_BITS + WORD_BITS;

    typedef enum logic [2:0] {
        IDLE, TAG, WB_RD, WB_WR, FILL, REPLAY
    } state_t;

    state_t                state_q;
    logic [WORD_BITS-1:0]  wcnt_q;
    logic                  first_q;
    logic                  we_q;
    logic [ADDR_BITS-1:0]  addr_q;
    logic [2:0]            ubhw_q;
    logic [31:0]           wdata_q;
    logic [TAG_BITS-1:0]   vtag_q;
    logic                  ready_q;
    logic [31:0]           rdata_q;
    logic                  mem_cs_q;
    logic                  mem_we_q;
    logic [ADDR_BITS-1:0]  mem_addr_q;
    logic [31:0]           mem_data_q;
    logic [CNT_BITS-1:0]   hit_cnt_q;
    logic [CNT_BITS-1:0]   miss_cnt_q;

    logic [INDEX_BITS-1:0] idx;
    logic [ADDR_BITS-1:0]  fill_addr;
    logic [ADDR_BITS-1:0]  wb_addr;
    logic                  last_word;

    assign idx       = addr_q[IDX_LO +: INDEX_BITS];
    assign fill_addr = {addr_q[ADDR_BITS-1:IDX_LO], wcnt_q, {OFF_BITS{1'b0}}};
    assign wb_addr   = {vtag_q, idx, wcnt_q, {OFF_BITS{1'b0}}};
    assign last_word = (wcnt_q == '1);

    // Array strobes are combinational so the array samples them on the
    // same edge the FSM advances; the refill store rides on mem_ack_i.
    always_comb begin
        bus.cache_addr_o  = '0;
        bus.cache_load_o  = 1'b0;
        bus.cache_edit_o  = 1'b0;
        bus.cache_store_o = 1'b0;
        bus.cache_ubhw_o  = '0;
        bus.cache_din_o   = '0;
        case (state_q)
            IDLE: begin
                if (bus.cpu_req_i && !ready_q) begin
                    bus.cache_addr_o = bus.cpu_addr_i;
                    bus.cache_load_o = ~bus.cpu_we_i;
                    bus.cache_edit_o = bus.cpu_we_i;
                    bus.cache_ubhw_o = bus.cpu_ubhw_i;
                    bus.cache_din_o  = bus.cpu_data_i;
                end
            end
            REPLAY: begin
                bus.cache_addr_o = addr_q;
                bus.cache_load_o = ~we_q;
                bus.cache_edit_o = we_q;
                bus.cache_ubhw_o = ubhw_q;
                bus.cache_din_o  = wdata_q;
            end
            WB_RD: bus.cache_addr_o = fill_addr;
            FILL: begin
                if (mem_cs_q && bus.mem_ack_i) begin
                    bus.cache_addr_o  = mem_addr_q;
                    bus.cache_store_o = 1'b1;
                    bus.cache_din_o   = bus.mem_data_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wcnt_q     <= '0;
            first_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            ubhw_q     <= '0;
            wdata_q    <= '0;
            vtag_q     <= '0;
            ready_q    <= 1'b0;
            rdata_q    <= '0;
            mem_cs_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.cpu_req_i && !ready_q) begin
                        we_q    <= bus.cpu_we_i;
                        addr_q  <= bus.cpu_addr_i;
                        ubhw_q  <= bus.cpu_ubhw_i;
                        wdata_q <= bus.cpu_data_i;
                        first_q <= 1'b1;
                        state_q <= TAG;
                    end
                end
                TAG: begin
                    wcnt_q <= '0;
                    if (bus.cache_hit_i) begin
                        ready_q <= 1'b1;
                        rdata_q <= bus.cache_dout_i;
                        if (first_q) hit_cnt_q <= hit_cnt_q + CNT_BITS'(1);
                        state_q <= IDLE;
                    end else begin
                        if (first_q) miss_cnt_q <= miss_cnt_q + CNT_BITS'(1);
                        if (first_q && bus.cache_valid_i && bus.cache_dirty_i) begin
                            vtag_q  <= bus.cache_tag_i;
                            state_q <= WB_RD;
                        end else begin
                            state_q <= FILL;
                        end
                    end
                end
                WB_RD: state_q <= WB_WR;
                // First WB_WR cycle captures the victim word read in WB_RD.
                WB_WR: begin
                    if (!mem_cs_q) begin
                        mem_cs_q   <= 1'b1;
                        mem_we_q   <= 1'b1;
                        mem_addr_q <= wb_addr;
                        mem_data_q <= bus.cache_dout_i;
                    end else if (bus.mem_ack_i) begin
                        mem_cs_q <= 1'b0;
                        mem_we_q <= 1'b0;
                        wcnt_q   <= wcnt_q + WORD_BITS'(1);
                        state_q  <= last_word ? FILL : WB_RD;
                    end
                end
                FILL: begin
                    if (!mem_cs_q) begin
                        mem_cs_q   <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= fill_addr;
                    end else if (bus.mem_ack_i) begin
                        mem_cs_q <= 1'b0;
                        wcnt_q   <= wcnt_q + WORD_BITS'(1);
                        if (last_word) state_q <= REPLAY;
                    end
                end
                REPLAY: begin
                    first_q <= 1'b0;
                    state_q <= TAG;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cache_inv_o = 1'b0;
    assign bus.cpu_ready_o = ready_q;
    assign bus.cpu_data_o  = rdata_q;
    assign bus.mem_cs_o    = mem_cs_q;
    assign bus.mem_we_o    = mem_we_q;
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.mem_data_o  = mem_data_q;
    assign bus.hit_cnt_o   = hit_cnt_q;
    assign bus.miss_cnt_o  = miss_cnt_q;
endmodule
